// File: rtl/jpeg_idct_transpose.sv
// Double-buffered 8x8 transpose between the IDCT row and column passes.
// Samples are written row-major into one bank while the other bank is read column-major.
module jpeg_idct_transpose #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inport_valid_i,
    input  logic [WIDTH-1:0] inport_data_i,
    output logic             inport_accept_o,
    input  logic             flush_i,
    output logic             outport_valid_o,
    output logic [WIDTH-1:0] outport_data_o,
    output logic [5:0]       outport_idx_o,
    output logic             outport_last_o,
    input  logic             outport_accept_i
);

    // Bank select is the top address bit: {bank, row, col}.
    logic [WIDTH-1:0] mem [0:127];

    logic             wr_bank;
    logic             rd_bank;
    logic [5:0]       wr_cnt;
    logic [5:0]       rd_cnt;
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [5:0]       out_idx;
    logic             out_last;
    logic             push;
    logic             issue;
    logic [5:0]       rd_addr;

    assign inport_accept_o = !full[wr_bank];
    assign push            = inport_valid_i && inport_accept_o;
    assign issue           = full[rd_bank] && (!out_valid || outport_accept_i);
    // Output position k walks down a column: row = k[2:0], col = k[5:3].
    assign rd_addr         = {rd_cnt[2:0], rd_cnt[5:3]};

    // NOTE: full_next takes the current value first so every path assigns it and no latch is inferred.
    always_comb begin
        full_next = full;
        if (push && wr_cnt == 6'd63) begin
            full_next[wr_bank] = 1'b1;
        end
        if (issue && rd_cnt == 6'd63) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    // NOTE: the sample memory has no reset; full flags guard every read, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[{wr_bank, wr_cnt}] <= inport_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= 6'd0;
            rd_cnt    <= 6'd0;
            full      <= 2'b00;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= 6'd0;
            out_last  <= 1'b0;
        end else begin
            full <= full_next;
            if (push) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (issue) begin
                rd_cnt    <= rd_cnt + 6'd1;
                out_valid <= 1'b1;
                out_data  <= mem[{rd_bank, rd_addr}];
                out_idx   <= rd_cnt;
                out_last  <= (rd_cnt == 6'd63);
                if (rd_cnt == 6'd63) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (outport_accept_i) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign outport_valid_o = out_valid;
    assign outport_data_o  = out_data;
    assign outport_idx_o   = out_idx;
    assign outport_last_o  = out_last;

endmodule

// File: tb/tb_jpeg_idct_transpose.sv
// Directed and random checks of the 8x8 transpose buffer using a transposed-order scoreboard.
module tb_jpeg_idct_transpose;

    typedef struct {
        logic [15:0] data;
        logic [5:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        inport_valid_i = 1'b0;
    logic [15:0] inport_data_i = '0;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [15:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic        outport_last_o;
    logic        outport_accept_i = 1'b1;

    int          n_assert = 0;
    int          n_fail = 0;
    int          stalls = 0;
    int          gaps = 0;
    bit          seen_first = 0;
    int          accept_mode = 0;  // 0: always accept, 1: never accept, 2: random
    exp_t        q[$];
    logic [15:0] blk_buf [64];
    int          blk_pos = 0;

    jpeg_idct_transpose #(.WIDTH(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_accept_o  (inport_accept_o),
        .flush_i          (flush_i),
        .outport_valid_o  (outport_valid_o),
        .outport_data_o   (outport_data_o),
        .outport_idx_o    (outport_idx_o),
        .outport_last_o   (outport_last_o),
        .outport_accept_i (outport_accept_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Once a block is complete, queue its 64 samples in column-major order.
    task automatic push_sample(input logic [15:0] d);
        blk_buf[blk_pos] = d;
        blk_pos++;
        if (blk_pos == 64) begin
            for (int k = 0; k < 64; k++) begin
                exp_t e;
                e.data = blk_buf[(k % 8) * 8 + (k / 8)];
                e.idx  = 6'(k);
                q.push_back(e);
            end
            blk_pos = 0;
        end
    endtask

    task automatic drive_cycle(input bit v, input logic [15:0] d, output bit acc);
        @(posedge clk);
        #1;
        inport_valid_i = v;
        inport_data_i  = d;
        case (accept_mode)
            0:       outport_accept_i = 1'b1;
            1:       outport_accept_i = 1'b0;
            default: outport_accept_i = 1'($urandom_range(1));
        endcase
        @(negedge clk);
        acc = v && inport_accept_o;
        if (v && !inport_accept_o) stalls++;
    endtask

    task automatic idle();
        bit acc;
        drive_cycle(1'b0, 16'h0, acc);
    endtask

    task automatic send(input logic [15:0] d, input int budget);
        bit acc = 0;
        int c = 0;
        while (!acc && c < budget) begin
            drive_cycle(1'b1, d, acc);
            c++;
        end
        check("send_accepted", 32'(acc), 32'd1);
        if (acc) push_sample(d);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((q.size() != 0 || outport_valid_o) && c < budget) begin
            idle();
            c++;
        end
        check("drain_complete", 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_accept"}, 32'(inport_accept_o), 32'd1);
        check({tag, "_valid"},  32'(outport_valid_o), 32'd0);
        check({tag, "_last"},   32'(outport_last_o),  32'd0);
        check({tag, "_idx"},    32'(outport_idx_o),   32'd0);
        check({tag, "_data"},   32'(outport_data_o),  32'd0);
    endtask

    // Output monitor: a transfer happens on the edge following a negedge where valid && accept.
    always @(negedge clk) begin
        if (!rst_i && !flush_i) begin
            if (outport_valid_o) seen_first = 1;
            if (seen_first && !outport_valid_o && q.size() != 0) gaps++;
            if (outport_valid_o && outport_accept_i) begin
                if (q.size() == 0) begin
                    check("out_unexpected", 32'(outport_data_o), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", 32'(outport_data_o), 32'(e.data));
                    check("out_idx",  32'(outport_idx_o),  32'(e.idx));
                    check("out_last", 32'(outport_last_o), 32'(e.idx == 6'd63));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int lat;
        int acc_cnt;
        int c;
        bit found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Single ramp block; edge N takes sample 63, edge N+1 loads the first output
        accept_mode = 0;
        for (int i = 0; i < 64; i++) send(16'(i), 4);
        lat = 0;
        do begin
            idle();
            lat++;
        end while (!outport_valid_o && lat < 10);
        check("first_out_latency", 32'(lat), 32'd2);
        wait_drain(200);

        // Three blocks back-to-back with downstream always ready
        stalls = 0;
        gaps = 0;
        seen_first = 0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++) send(16'(b * 256 + i * 3 + 7), 4);
        wait_drain(300);
        check("b2b_input_stalls", 32'(stalls), 32'd0);
        check("b2b_output_gaps", 32'(gaps), 32'd0);

        // Backpressure: two full blocks fill both banks, the third stalls
        accept_mode = 1;
        acc_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            send(16'(i), 4);
            acc_cnt++;
        end
        check("stall_accept_count", 32'(acc_cnt), 32'd128);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 16'h2000, acc);
            check("stall_accept_low", 32'(inport_accept_o), 32'd0);
            check("stall_out_valid",  32'(outport_valid_o), 32'd1);
            check("stall_out_data",   32'(outport_data_o),  32'd0);
            check("stall_out_idx",    32'(outport_idx_o),   32'd0);
        end
        accept_mode = 0;
        for (int i = 0; i < 5; i++) send(16'h2000 + 16'(i), 300);
        for (int i = 5; i < 64; i++) send(16'h2000 + 16'(i), 300);
        wait_drain(400);

        // Random valid/accept, random data with extreme values
        accept_mode = 2;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 64; i++) begin
                logic [15:0] d;
                d = 16'($urandom);
                if (i == 0) d = 16'hFFFF;
                if (i == 63) d = 16'h8000;
                while ($urandom_range(1) == 0) idle();
                send(d, 400);
            end
        end
        wait_drain(2000);

        // Flush after 30 samples of block 1 while block 0 drains
        accept_mode = 0;
        for (int i = 0; i < 64; i++) send(16'(i), 4);
        for (int i = 0; i < 30; i++) send(16'h3000 + 16'(i), 4);
        @(posedge clk);
        #1;
        inport_valid_i = 1'b0;
        flush_i = 1'b1;
        q.delete();
        blk_pos = 0;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(outport_valid_o), 32'd0);
        check("flush_in_accept", 32'(inport_accept_o), 32'd1);
        for (int i = 0; i < 64; i++) send(16'(i), 4);
        wait_drain(200);

        // Reset while the output is at k=20
        for (int i = 0; i < 64; i++) send(16'h4000 + 16'(i), 4);
        found = 0;
        c = 0;
        while (!found && c < 200) begin
            idle();
            found = outport_valid_o && outport_idx_o == 6'd20;
            c++;
        end
        check("reached_k20", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        q.delete();
        blk_pos = 0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_reset_values("midread_reset");
        for (int i = 0; i < 64; i++) send(16'h5000 + 16'(i), 4);
        wait_drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
